bcd_tick_counter: RTL and testbench

//  Downstream consumer of the divided clock from the counter-based frequency divider.

---
 rtl/tick_counter_pkg.sv | 20 ++
 rtl/sync_edge_detect.sv | 29 ++
 rtl/bcd_tick_counter.sv | 100 ++++++++++
 tb/tb_bcd_tick_counter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_counter_pkg.sv
// Shared definitions for the BCD tick counter: FSM state encodings, digit width
// and a single-digit BCD increment helper.
package tick_counter_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Returns {carry, next_digit}; a digit at or above its terminal value wraps to 0.
  function automatic logic [BCD_W:0] digit_inc(input logic [BCD_W-1:0] digit,
                                               input logic [BCD_W-1:0] max_val);
    if (digit >= max_val) return {1'b1, {BCD_W{1'b0}}};
    else                  return {1'b0, digit + BCD_W'(1)};
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous level into clk and emits a one-cycle pulse on
// each rising edge. Reusable for push-button inputs.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // NOTE: the whole chain is reset so no stale level can fake an edge after
  // reset; sequential state always uses non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/bcd_tick_counter.sv
// Counts rising edges of a slow divided clock as a two-digit BCD value under
// start/stop/clear control, with a registered wrap pulse.
module bcd_tick_counter
  import tick_counter_pkg::*;
#(
  parameter int MAX_ONES    = 9,
  parameter int MAX_TENS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [BCD_W-1:0] bcd_ones,
  output logic [BCD_W-1:0] bcd_tens,
  output logic             running,
  output logic             rollover
);

  localparam logic [BCD_W-1:0] ONES_MAX = BCD_W'(MAX_ONES);
  localparam logic [BCD_W-1:0] TENS_MAX = BCD_W'(MAX_TENS);

  state_t           r_state;
  logic [BCD_W-1:0] r_ones;
  logic [BCD_W-1:0] r_tens;
  logic             r_running;
  logic             r_rollover;

  logic             w_tick;
  logic [BCD_W:0]   w_ones_inc;
  logic [BCD_W:0]   w_tens_inc;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .rst        (rst),
    .async_in   (slow_in),
    .rise_pulse (w_tick)
  );

  assign w_ones_inc = digit_inc(r_ones, ONES_MAX);
  assign w_tens_inc = digit_inc(r_tens, TENS_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ones     <= '0;
      r_tens     <= '0;
      r_running  <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      // NOTE: default-low first makes rollover a single-cycle pulse.
      r_rollover <= 1'b0;
      if (clear) begin
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
        r_ones    <= '0;
        r_tens    <= '0;
      end else begin
        case (r_state)
          ST_IDLE, ST_PAUSE: begin
            // stop outranks start; a tick in this cycle is dropped
            if (!stop && start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_tick) begin
              r_ones <= w_ones_inc[BCD_W-1:0];
              if (w_ones_inc[BCD_W]) begin
                r_tens     <= w_tens_inc[BCD_W-1:0];
                r_rollover <= w_tens_inc[BCD_W];
              end
            end
            if (stop) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_ones    <= '0;
            r_tens    <= '0;
          end
        endcase
      end
    end
  end

  assign bcd_ones = r_ones;
  assign bcd_tens = r_tens;
  assign running  = r_running;
  assign rollover = r_rollover;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter: table-driven control sequences,
// hand-written corner cases and a randomized run against a behavioural model.
module tb_bcd_tick_counter;

  logic       clk = 1'b0;
  logic       rst, slow_in, start, stop, clear;
  logic [3:0] bcd_ones, bcd_tens, ones2, tens2;
  logic       running, rollover, running2, rollover2;

  int checks = 0;
  int errors = 0;
  int roll_cnt = 0;
  int roll_cnt2 = 0;

  always #5 clk = ~clk;

  bcd_tick_counter dut (
    .clk(clk), .rst(rst), .slow_in(slow_in), .start(start), .stop(stop), .clear(clear),
    .bcd_ones(bcd_ones), .bcd_tens(bcd_tens), .running(running), .rollover(rollover)
  );

  bcd_tick_counter #(.MAX_ONES(3), .MAX_TENS(0), .SYNC_STAGES(2)) dut_small (
    .clk(clk), .rst(rst), .slow_in(slow_in), .start(start), .stop(stop), .clear(clear),
    .bcd_ones(ones2), .bcd_tens(tens2), .running(running2), .rollover(rollover2)
  );

  always @(negedge clk) begin
    if (rollover)  roll_cnt++;
    if (rollover2) roll_cnt2++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bcd_of(input int v);
    return {24'd0, 4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check_count(input string name, input int v);
    check(name, {24'd0, bcd_tens, bcd_ones}, bcd_of(v));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    slow_in = 1'b1;
    repeat (4) step();
    slow_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_once();
  endtask

  task automatic pulse_ctrl(input bit s, input bit p, input bit c);
    start = s; stop = p; clear = c;
    step();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  typedef struct {
    bit start;
    bit stop;
    bit clear;
    int n_ticks;
    int count;
    bit run;
  } vec_t;

  typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;

  vec_t vecs[11];

  initial begin
    int r0, r2;
    mode_t mode;
    int cnt, cnt2;
    bit e_roll, e_roll2, tk, c, p, s;
    bit hist[$];

    vecs[0]  = '{0, 0, 1, 0,  0, 0};
    vecs[1]  = '{0, 0, 0, 3,  0, 0};
    vecs[2]  = '{1, 0, 0, 12, 12, 1};
    vecs[3]  = '{0, 1, 0, 5,  12, 0};
    vecs[4]  = '{1, 0, 0, 1,  13, 1};
    vecs[5]  = '{0, 0, 0, 10, 23, 1};
    vecs[6]  = '{1, 1, 0, 0,  23, 0};
    vecs[7]  = '{1, 0, 0, 0,  23, 1};
    vecs[8]  = '{0, 0, 1, 2,  0, 0};
    vecs[9]  = '{1, 0, 0, 9,  9, 1};
    vecs[10] = '{0, 0, 0, 1,  10, 1};

    rst = 1'b1; slow_in = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (3) step();
    check_count("reset_count", 0);
    check("reset_running", {31'd0, running}, 32'd0);
    check("reset_rollover", {31'd0, rollover}, 32'd0);
    rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 11; i++) begin
      pulse_ctrl(vecs[i].start, vecs[i].stop, vecs[i].clear);
      ticks(vecs[i].n_ticks);
      check_count($sformatf("vec%0d_count", i), vecs[i].count);
      check($sformatf("vec%0d_running", i), {31'd0, running}, {31'd0, vecs[i].run});
    end

    // Latency: rise before E0, count moves at E2
    pulse_ctrl(0, 0, 1);
    pulse_ctrl(1, 0, 0);
    check("latency_running", {31'd0, running}, 32'd1);
    slow_in = 1'b1;
    step(); check_count("latency_e0", 0);
    step(); check_count("latency_e1", 0);
    step(); check_count("latency_e2", 1);
    slow_in = 1'b0;
    repeat (4) step();
    ticks(3);
    check_count("latency_periods", 4);

    // Wrap 59 -> 00 and the 0:3 instance wrapping 3 -> 0
    pulse_ctrl(0, 0, 1);
    pulse_ctrl(1, 0, 0);
    r2 = roll_cnt2;
    ticks(59);
    check_count("wrap_at_59", 59);
    check("small_at_59", {24'd0, tens2, ones2}, 32'd3);
    r0 = roll_cnt;
    tick_once();
    check_count("wrap_to_00", 0);
    check("wrap_roll_cycles", roll_cnt - r0, 32'd1);
    check("wrap_roll_low", {31'd0, rollover}, 32'd0);
    check("small_after_60", {24'd0, tens2, ones2}, 32'd0);
    check("small_roll_cycles", roll_cnt2 - r2, 32'd15);

    // clear with tick at 58
    pulse_ctrl(0, 0, 1);
    pulse_ctrl(1, 0, 0);
    ticks(58);
    check_count("pre_clear_58", 58);
    r0 = roll_cnt;
    slow_in = 1'b1;
    step(); step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_count("clear_tick_count", 0);
    check("clear_tick_running", {31'd0, running}, 32'd0);
    slow_in = 1'b0;
    repeat (4) step();
    check("clear_tick_no_roll", roll_cnt - r0, 32'd0);

    // stop with tick in RUN: counted, then paused
    pulse_ctrl(1, 0, 0);
    ticks(4);
    slow_in = 1'b1;
    step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_count("stop_tick_count", 5);
    check("stop_tick_running", {31'd0, running}, 32'd0);
    slow_in = 1'b0;
    repeat (4) step();
    tick_once();
    check_count("paused_drop", 5);

    // start with tick in PAUSE: not counted
    slow_in = 1'b1;
    step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_count("start_tick_count", 5);
    check("start_tick_running", {31'd0, running}, 32'd1);
    slow_in = 1'b0;
    repeat (4) step();
    tick_once();
    check_count("start_next_tick", 6);

    // level held high: one increment only
    slow_in = 1'b1;
    repeat (100) step();
    check_count("hold_high", 7);
    slow_in = 1'b0;
    repeat (4) step();
    check_count("hold_fall", 7);

    // async reset mid-run at 37, checked before any clock edge
    ticks(30);
    check_count("pre_reset_37", 37);
    #1 rst = 1'b1;
    #1;
    check_count("async_reset_count", 0);
    check("async_reset_running", {31'd0, running}, 32'd0);
    step();
    rst = 1'b0;
    step();
    tick_once();
    check_count("post_reset_idle", 0);
    check("post_reset_running", {31'd0, running}, 32'd0);

    // randomized run with a 32:1 divided input against the model
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    hist = '{1'b0, 1'b0, 1'b0};
    mode = M_IDLE; cnt = 0; cnt2 = 0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      int rv;
      rv = int'($urandom_range(0, 99));
      c = (rv < 2);
      p = (rv >= 2 && rv < 7);
      s = (rv >= 7 && rv < 15);
      start = s; stop = p; clear = c;
      slow_in = ((cyc % 32) < 16);
      hist.push_back(slow_in);
      if (hist.size() > 8) void'(hist.pop_front());
      tk = hist[$-2] & ~hist[$-3];
      e_roll = 1'b0; e_roll2 = 1'b0;
      if (c) begin
        mode = M_IDLE; cnt = 0; cnt2 = 0;
      end else if (mode == M_RUN) begin
        if (tk) begin
          e_roll  = (cnt == 59);
          cnt     = (cnt + 1) % 60;
          e_roll2 = (cnt2 == 3);
          cnt2    = (cnt2 + 1) % 4;
        end
        if (p) mode = M_PAUSE;
      end else if (s) begin
        mode = M_RUN;
      end
      step();
      check($sformatf("rand%0d_main", cyc), {22'd0, bcd_tens, bcd_ones, running, rollover},
            {22'd0, 4'(cnt / 10), 4'(cnt % 10), mode == M_RUN, e_roll});
      check($sformatf("rand%0d_small", cyc), {22'd0, tens2, ones2, running2, rollover2},
            {22'd0, 4'd0, 4'(cnt2), mode == M_RUN, e_roll2});
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0; slow_in = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
